// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32I control FSM driving the datapath selects and enables.
// Optional macro MC_CTRL_TRAP_EN: an illegal instruction parks the FSM in HALT until reset.
module mc_controller #(
    parameter int MEM_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op_code,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    output logic       adr_src,
    output logic       mem_write,
    output logic       IR_write,
    output logic       reg_write,
    output logic       PC_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic       illegal,
    output logic       retire
);

    typedef enum logic [4:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_LINK,
        S_LUI, S_AUIPC, S_ILLEGAL, S_HALT
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_cnt;
    logic       r_illegal;
    logic       w_hold;
    logic       w_cnt_done;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_pc_write;
    logic       w_retire;
    logic       w_unused;

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Only funct7[5] distinguishes SUB/SRA; the remaining bits are ignored.
    assign w_unused = ^{funct7[6], funct7[4:0]};

    assign w_hold     = (r_state == S_FETCH) || (r_state == S_MEMREAD);
    assign w_cnt_done = (r_cnt == LAT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_hold && !w_cnt_done)
                r_cnt <= r_cnt + 3'd1;
            else
                r_cnt <= '0;
            if (w_next == S_ILLEGAL)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next      = r_state;
        adr_src     = 1'b0;
        result_src  = 2'd0;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        imm_src     = 3'd0;
        alu_control = ALU_ADD;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_pc_write  = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                if (w_cnt_done) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU_out captures old_PC + imm as the branch/JAL target.
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                imm_src   = (op_code == OP_JAL) ? 3'd3 : 3'd2;
                case (op_code)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXECR;
                    OP_I:              w_next = S_EXECI;
                    OP_BR:             w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    OP_AUIPC:          w_next = S_AUIPC;
                    OP_FENCE: begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    default:           w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                if (op_code == OP_STORE) begin
                    imm_src = 3'd1;
                    w_next  = S_MEMWRITE;
                end else begin
                    w_next  = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (w_cnt_done)
                    w_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'd1;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = 2'd2;
                alu_control = alu_decode(funct3, funct7[5]);
                w_next      = S_ALUWB;
            end
            S_EXECI: begin
                // ADDI has no SUB form; funct7[5] only selects SRAI.
                alu_src_a   = 2'd2;
                alu_src_b   = 2'd1;
                alu_control = alu_decode(funct3, (funct3 == 3'b101) && funct7[5]);
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'd2;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
                case (funct3)
                    3'b000: begin alu_control = ALU_SUB;  w_pc_write = Zero;  end
                    3'b001: begin alu_control = ALU_SUB;  w_pc_write = ~Zero; end
                    3'b100: begin alu_control = ALU_SLT;  w_pc_write = ~Zero; end
                    3'b101: begin alu_control = ALU_SLT;  w_pc_write = Zero;  end
                    3'b110: begin alu_control = ALU_SLTU; w_pc_write = ~Zero; end
                    3'b111: begin alu_control = ALU_SLTU; w_pc_write = Zero;  end
                    default: begin
                        w_retire = 1'b0;
                        w_next   = S_ILLEGAL;
                    end
                endcase
            end
            S_JAL: begin
                w_pc_write = 1'b1;
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd2;
                w_next     = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a  = 2'd2;
                alu_src_b  = 2'd1;
                result_src = 2'd2;
                w_pc_write = 1'b1;
                w_next     = S_JALR_LINK;
            end
            S_JALR_LINK: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                w_next    = S_ALUWB;
            end
            S_LUI: begin
                imm_src     = 3'd4;
                result_src  = 2'd3;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_AUIPC: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                imm_src   = 3'd4;
                w_next    = S_ALUWB;
            end
            S_ILLEGAL: begin
`ifdef MC_CTRL_TRAP_EN
                w_next = S_HALT;
`else
                w_next = S_FETCH;
`endif
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // Holding reset low suppresses every write, including mid-instruction.
    assign mem_write = w_mem_write & reset;
    assign IR_write  = w_ir_write & reset;
    assign reg_write = w_reg_write & reset;
    assign PC_write  = w_pc_write & reset;
    assign retire    = w_retire & reset;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: per-cycle expected control vectors from a table, checked via a scoreboard queue.
module tb_mc_controller;

    localparam int MEM_LATENCY = 1;

    typedef struct packed {
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic       pcw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       ret;
        logic       ill;
    } ctl_t;

    typedef struct {
        string      nm;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       z;
        ctl_t       d;
        int         n;
        ctl_t [0:3] tail;
    } ent_t;

    logic       clk;
    logic       reset;
    logic [6:0] op_code;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       adr_src, mem_write, IR_write, reg_write, PC_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       illegal, retire;

    int   errors = 0;
    int   checks = 0;
    logic sticky = 1'b0;
    ctl_t sb[$];
    ent_t tbl[$];

    ctl_t F1, F2, DB, DJ, DF, ALUWB, MAL, MAS, MR, MWB, MW, JAL, JALR, JLINK, LUI, AUIPC, ILL, NONE;

    mc_controller #(.MEM_LATENCY(MEM_LATENCY)) dut (
        .clk(clk), .reset(reset), .op_code(op_code), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .adr_src(adr_src), .mem_write(mem_write), .IR_write(IR_write),
        .reg_write(reg_write), .PC_write(PC_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control), .illegal(illegal), .retire(retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic ctl_t mk(input logic adr, mw, irw, rw, pcw,
                                input logic [1:0] rs, sa, sb_, input logic [2:0] imm,
                                input logic [3:0] alu, input logic ret, ill);
        ctl_t c;
        c = {adr, mw, irw, rw, pcw, rs, sa, sb_, imm, alu, ret, ill};
        return c;
    endfunction

    function automatic ctl_t exr(input logic [3:0] alu);
        return mk(0,0,0,0,0, 2'd0,2'd2,2'd0, 3'd0, alu, 0,0);
    endfunction

    function automatic ctl_t exi(input logic [3:0] alu);
        return mk(0,0,0,0,0, 2'd0,2'd2,2'd1, 3'd0, alu, 0,0);
    endfunction

    function automatic ctl_t br(input logic [3:0] alu, input logic pcw);
        return mk(0,0,0,0,pcw, 2'd0,2'd2,2'd0, 3'd0, alu, 1,0);
    endfunction

    task automatic add(input string nm, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic z, input ctl_t d, input int n,
                       input ctl_t t0, input ctl_t t1, input ctl_t t2, input ctl_t t3);
        ent_t e;
        e.nm = nm; e.op = op; e.f3 = f3; e.f7 = f7; e.z = z; e.d = d; e.n = n;
        e.tail[0] = t0; e.tail[1] = t1; e.tail[2] = t2; e.tail[3] = t3;
        tbl.push_back(e);
    endtask

    task automatic check_vec(input string nm, input int k, input ctl_t e);
        ctl_t a;
        ctl_t w;
        a = {adr_src, mem_write, IR_write, reg_write, PC_write, result_src, alu_src_a,
             alu_src_b, imm_src, alu_control, retire, illegal};
        w = e;
        if (sticky) w.ill = 1'b1;
        if (e.ill) sticky = 1'b1;
        checks++;
        if (a !== w) begin
            errors++;
            $display("FAIL %s cycle %0d: got %05h required %05h", nm, k, a, w);
        end
    endtask

    task automatic check_en(input string nm);
        checks++;
        if ({mem_write, IR_write, reg_write, PC_write} !== 4'b0000) begin
            errors++;
            $display("FAIL %s: enables got %b required 0000", nm,
                     {mem_write, IR_write, reg_write, PC_write});
        end
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            check_vec(nm, k, sb.pop_front());
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_entry(input ent_t e);
        op_code = e.op; funct3 = e.f3; funct7 = e.f7; Zero = e.z;
        for (int m = 0; m <= MEM_LATENCY; m++)
            sb.push_back((m == MEM_LATENCY) ? F2 : F1);
        sb.push_back(e.d);
        for (int t = 0; t < e.n; t++) sb.push_back(e.tail[t]);
        drain(e.nm);
    endtask

    initial begin
        F1    = mk(0,0,0,0,0, 2'd2,2'd0,2'd2, 3'd0, 4'd0, 0,0);
        F2    = mk(0,0,1,0,1, 2'd2,2'd0,2'd2, 3'd0, 4'd0, 0,0);
        DB    = mk(0,0,0,0,0, 2'd0,2'd1,2'd1, 3'd2, 4'd0, 0,0);
        DJ    = mk(0,0,0,0,0, 2'd0,2'd1,2'd1, 3'd3, 4'd0, 0,0);
        DF    = mk(0,0,0,0,0, 2'd0,2'd1,2'd1, 3'd2, 4'd0, 1,0);
        ALUWB = mk(0,0,0,1,0, 2'd0,2'd0,2'd0, 3'd0, 4'd0, 1,0);
        MAL   = mk(0,0,0,0,0, 2'd0,2'd2,2'd1, 3'd0, 4'd0, 0,0);
        MAS   = mk(0,0,0,0,0, 2'd0,2'd2,2'd1, 3'd1, 4'd0, 0,0);
        MR    = mk(1,0,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 4'd0, 0,0);
        MWB   = mk(0,0,0,1,0, 2'd1,2'd0,2'd0, 3'd0, 4'd0, 1,0);
        MW    = mk(1,1,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 4'd0, 1,0);
        JAL   = mk(0,0,0,0,1, 2'd0,2'd1,2'd2, 3'd0, 4'd0, 0,0);
        JALR  = mk(0,0,0,0,1, 2'd2,2'd2,2'd1, 3'd0, 4'd0, 0,0);
        JLINK = mk(0,0,0,0,0, 2'd0,2'd1,2'd2, 3'd0, 4'd0, 0,0);
        LUI   = mk(0,0,0,1,0, 2'd3,2'd0,2'd0, 3'd4, 4'd0, 1,0);
        AUIPC = mk(0,0,0,0,0, 2'd0,2'd1,2'd1, 3'd4, 4'd0, 0,0);
        ILL   = mk(0,0,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 4'd0, 0,1);
        NONE  = '0;

        add("sub",   7'b0110011, 3'b000, 7'b0100000, 0, DB, 2, exr(4'd1), ALUWB, NONE, NONE);
        add("add",   7'b0110011, 3'b000, 7'b0000000, 0, DB, 2, exr(4'd0), ALUWB, NONE, NONE);
        add("sll",   7'b0110011, 3'b001, 7'b0000000, 0, DB, 2, exr(4'd7), ALUWB, NONE, NONE);
        add("sltu",  7'b0110011, 3'b011, 7'b0000000, 0, DB, 2, exr(4'd6), ALUWB, NONE, NONE);
        add("sra",   7'b0110011, 3'b101, 7'b0100000, 0, DB, 2, exr(4'd9), ALUWB, NONE, NONE);
        add("or",    7'b0110011, 3'b110, 7'b0000000, 0, DB, 2, exr(4'd3), ALUWB, NONE, NONE);
        add("and",   7'b0110011, 3'b111, 7'b0000000, 0, DB, 2, exr(4'd2), ALUWB, NONE, NONE);
        add("addi",  7'b0010011, 3'b000, 7'b0100000, 0, DB, 2, exi(4'd0), ALUWB, NONE, NONE);
        add("srai",  7'b0010011, 3'b101, 7'b0100000, 0, DB, 2, exi(4'd9), ALUWB, NONE, NONE);
        add("srli",  7'b0010011, 3'b101, 7'b0000000, 0, DB, 2, exi(4'd8), ALUWB, NONE, NONE);
        add("xori",  7'b0010011, 3'b100, 7'b0000000, 0, DB, 2, exi(4'd4), ALUWB, NONE, NONE);
        add("slti",  7'b0010011, 3'b010, 7'b0000000, 0, DB, 2, exi(4'd5), ALUWB, NONE, NONE);
        add("load",  7'b0000011, 3'b010, 7'b0000000, 0, DB, 4, MAL, MR, MR, MWB);
        add("store", 7'b0100011, 3'b010, 7'b0000000, 0, DB, 2, MAS, MW, NONE, NONE);
        add("bne_z0",7'b1100011, 3'b001, 7'b0000000, 0, DB, 1, br(4'd1, 1), NONE, NONE, NONE);
        add("bne_z1",7'b1100011, 3'b001, 7'b0000000, 1, DB, 1, br(4'd1, 0), NONE, NONE, NONE);
        add("bge_z1",7'b1100011, 3'b101, 7'b0000000, 1, DB, 1, br(4'd5, 1), NONE, NONE, NONE);
        add("bltu_z0",7'b1100011,3'b110, 7'b0000000, 0, DB, 1, br(4'd6, 1), NONE, NONE, NONE);
        add("beq_z1",7'b1100011, 3'b000, 7'b0000000, 1, DB, 1, br(4'd1, 1), NONE, NONE, NONE);
        add("jal",   7'b1101111, 3'b000, 7'b0000000, 0, DJ, 2, JAL, ALUWB, NONE, NONE);
        add("jalr",  7'b1100111, 3'b000, 7'b0000000, 0, DB, 3, JALR, JLINK, ALUWB, NONE);
        add("lui",   7'b0110111, 3'b000, 7'b0000000, 0, DB, 1, LUI, NONE, NONE, NONE);
        add("auipc", 7'b0010111, 3'b000, 7'b0000000, 0, DB, 2, AUIPC, ALUWB, NONE, NONE);
        add("fence", 7'b0001111, 3'b000, 7'b0000000, 0, DF, 0, NONE, NONE, NONE, NONE);
        add("illop", 7'b1110011, 3'b000, 7'b0000000, 0, DB, 1, ILL, NONE, NONE, NONE);

        reset = 1'b0; op_code = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0; Zero = 1'b0;
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_en("reset_en");
            check_vec("reset_state", r, F1);
        end
        @(posedge clk); #1;
        reset = 1'b1;

        foreach (tbl[i]) run_entry(tbl[i]);

`ifdef MC_CTRL_TRAP_EN
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_vec("halt", c, ILL);
            @(posedge clk); #1;
        end
`else
        for (int m = 0; m <= MEM_LATENCY; m++)
            sb.push_back((m == MEM_LATENCY) ? F2 : F1);
        drain("resume");
`endif

        reset = 1'b0;
        @(negedge clk);
        check_en("rst_after_ill_en");
        @(posedge clk); #1;
        sticky = 1'b0;
        @(negedge clk);
        check_vec("rst_after_ill_state", 0, F1);
        @(posedge clk); #1;
        reset = 1'b1;

        // Abort a store in its MEMWRITE cycle: the write must be suppressed.
        op_code = 7'b0100011; funct3 = 3'b010; funct7 = 7'b0; Zero = 1'b0;
        for (int m = 0; m <= MEM_LATENCY; m++)
            sb.push_back((m == MEM_LATENCY) ? F2 : F1);
        sb.push_back(DB);
        sb.push_back(MAS);
        drain("store_pre_abort");
        reset = 1'b0;
        @(negedge clk);
        check_en("abort_store_en");
        @(posedge clk); #1;
        reset = 1'b1;
        foreach (tbl[i]) if (tbl[i].nm == "lui") run_entry(tbl[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
